// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared Space Invaders game-phase encodings and defaults
package invaders_pkg;

  typedef enum logic [2:0] {
    GS_IDLE    = 3'd0,
    GS_PLAY    = 3'd1,
    GS_RESPAWN = 3'd2,
    GS_WIN     = 3'd3,
    GS_LOSE    = 3'd4
  } game_state_e;

  localparam int LIVES_INIT_DEF    = 3;
  localparam int FIRE_COOLDOWN_DEF = 8;
  localparam int RESPAWN_TICKS_DEF = 32;

endpackage

// File: rtl/game_sequencer_fire_ctrl.sv
// rtl/game_sequencer_fire_ctrl.sv - fire button edge detect, cooldown and single-cycle shot pulse
module fire_ctrl #(
  parameter int FIRE_COOLDOWN = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Tick,
  input  logic Fire_Btn,
  input  logic Bullet_Onscreen,
  input  logic play,
  input  logic clear,
  output logic Bullet_Fired
);

  logic       fire_prev_q, fire_prev_d;
  logic [7:0] cooldown_q, cooldown_d;
  logic       bullet_fired_q, bullet_fired_d;
  logic       accept;

  always_comb begin
    // Rejected edges are simply lost; nothing remembers them for later.
    accept         = Fire_Btn && !fire_prev_q && play && !Bullet_Onscreen && (cooldown_q == 8'd0);
    fire_prev_d    = Fire_Btn;
    bullet_fired_d = accept;
    cooldown_d     = cooldown_q;
    if (clear) begin
      cooldown_d = 8'd0;
    end else if (accept) begin
      cooldown_d = 8'(FIRE_COOLDOWN);
    end else if (play && Tick && (cooldown_q != 8'd0)) begin
      cooldown_d = cooldown_q - 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fire_prev_q    <= 1'b0;
      cooldown_q     <= 8'd0;
      bullet_fired_q <= 1'b0;
    end else begin
      fire_prev_q    <= fire_prev_d;
      cooldown_q     <= cooldown_d;
      bullet_fired_q <= bullet_fired_d;
    end
  end

  assign Bullet_Fired = bullet_fired_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game-phase FSM, score and lives for the Space Invaders datapath
module game_sequencer
  import invaders_pkg::*;
#(
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int FIRE_COOLDOWN = FIRE_COOLDOWN_DEF,
  parameter int RESPAWN_TICKS = RESPAWN_TICKS_DEF,
  parameter int SCORE_W       = 10,
  parameter int HIT_POINTS    = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Fire_Btn,
  input  logic               Bullet_Onscreen,
  input  logic               Alien_Hit,
  input  logic               Aliens_Defeated,
  input  logic               Reached_Bottom,
  input  logic               Player_Hit,
  output logic               Game_Run,
  output logic               Bullet_Fired,
  output logic               Clear_Field,
  output logic [2:0]         Game_State,
  output logic [1:0]         Lives,
  output logic [SCORE_W-1:0] Score
);

  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [2:0]         state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;
  logic [7:0]         resp_q, resp_d;
  logic               clear_q, clear_d;
  logic               game_run_q, game_run_d;
  logic               start_game;
  logic               in_play;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= GS_IDLE;
      lives_q    <= 2'd0;
      score_q    <= '0;
      resp_q     <= 8'd0;
      clear_q    <= 1'b0;
      game_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      resp_q     <= resp_d;
      clear_q    <= clear_d;
      game_run_q <= game_run_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    resp_d     = resp_q;
    clear_d    = 1'b0;
    start_game = 1'b0;
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(HIT_POINTS);
    case (state_q)
      GS_IDLE: begin
        if (Start) begin
          state_d    = GS_PLAY;
          lives_d    = LIVES_LOAD;
          score_d    = '0;
          clear_d    = 1'b1;
          start_game = 1'b1;
        end
      end
      GS_PLAY: begin
        // Start switch dropping abandons the game ahead of any in-play event.
        if (!Start) begin
          state_d = GS_IDLE;
        end else if (Reached_Bottom) begin
          state_d = GS_LOSE;
          lives_d = 2'd0;
        end else if (Aliens_Defeated) begin
          state_d = GS_WIN;
        end else if (Player_Hit && (lives_q == 2'd1)) begin
          state_d = GS_LOSE;
          lives_d = 2'd0;
        end else if (Player_Hit) begin
          state_d = GS_RESPAWN;
          lives_d = lives_q - 2'd1;
          resp_d  = 8'(RESPAWN_TICKS);
          clear_d = 1'b1;
        end
      end
      GS_RESPAWN: begin
        if (!Start) begin
          state_d = GS_IDLE;
        end else if (Tick && (resp_q != 8'd0)) begin
          resp_d = resp_q - 8'd1;
          if (resp_q == 8'd1) state_d = GS_PLAY;
        end
      end
      GS_WIN, GS_LOSE: begin
        if (!Start) state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
    // Hits landing in the same cycle as a PLAY exit still score.
    if ((state_q == GS_PLAY) && Alien_Hit) begin
      score_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end
  end

  always_comb begin
    in_play     = (state_q == GS_PLAY);
    game_run_d  = in_play;
    Game_Run    = game_run_q;
    Clear_Field = clear_q;
    Game_State  = state_q;
    Lives       = lives_q;
    Score       = score_q;
  end

  fire_ctrl #(
    .FIRE_COOLDOWN(FIRE_COOLDOWN)
  ) u_fire_ctrl (
    .Clk            (Clk),
    .Reset          (Reset),
    .Tick           (Tick),
    .Fire_Btn       (Fire_Btn),
    .Bullet_Onscreen(Bullet_Onscreen),
    .play           (in_play),
    .clear          (start_game),
    .Bullet_Fired   (Bullet_Fired)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed scoreboard bench for game_sequencer
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, start, fire_btn, bullet_onscreen;
  logic       alien_hit, aliens_defeated, reached_bottom, player_hit;
  logic       game_run, bullet_fired, clear_field;
  logic [2:0] game_state;
  logic [1:0] lives;
  logic [3:0] score;

  typedef struct {
    string tag;
    int    v;
  } sb_t;
  sb_t sb[$];

  int checks   = 0;
  int failures = 0;
  int pulses;
  int exp_score;

  game_sequencer #(.SCORE_W(4)) dut (
    .Clk            (clk),
    .Reset          (reset),
    .Tick           (tick),
    .Start          (start),
    .Fire_Btn       (fire_btn),
    .Bullet_Onscreen(bullet_onscreen),
    .Alien_Hit      (alien_hit),
    .Aliens_Defeated(aliens_defeated),
    .Reached_Bottom (reached_bottom),
    .Player_Hit     (player_hit),
    .Game_Run       (game_run),
    .Bullet_Fired   (bullet_fired),
    .Clear_Field    (clear_field),
    .Game_State     (game_state),
    .Lives          (lives),
    .Score          (score)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cycle();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic exp_push(input string tag, input int v);
    sb.push_back('{tag, v});
  endtask

  task automatic obs_pop(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === 32'(e.v)) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int v);
    exp_push(tag, v);
    obs_pop(obs);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; fire_btn = 1'b0; bullet_onscreen = 1'b0;
    alien_hit = 1'b0; aliens_defeated = 1'b0; reached_bottom = 1'b0; player_hit = 1'b0;
    step(); step();
    chk("reset_state", 32'(game_state), 0);
    chk("reset_run", 32'(game_run), 0);
    chk("reset_lives", 32'(lives), 0);
    chk("reset_score", 32'(score), 0);
    chk("reset_fired", 32'(bullet_fired), 0);
    chk("reset_clear", 32'(clear_field), 0);
    reset = 1'b0;
    step();

    // Game start
    start = 1'b1;
    step();
    chk("start_state", 32'(game_state), 1);
    chk("start_clear", 32'(clear_field), 1);
    chk("start_lives", 32'(lives), 3);
    chk("start_score", 32'(score), 0);
    chk("start_run_lag", 32'(game_run), 0);
    step();
    chk("start_clear_end", 32'(clear_field), 0);
    chk("start_run", 32'(game_run), 1);

    // First shot, dropped shot in cooldown, second shot after cooldown
    fire_btn = 1'b1;
    step();
    chk("fire_first", 32'(bullet_fired), 1);
    step();
    chk("fire_first_end", 32'(bullet_fired), 0);
    fire_btn = 1'b0;
    step();
    repeat (3) tick_cycle();
    fire_btn = 1'b1;
    step();
    chk("fire_cooldown_drop", 32'(bullet_fired), 0);
    fire_btn = 1'b0;
    step();
    repeat (5) tick_cycle();
    fire_btn = 1'b1;
    step();
    chk("fire_after_cooldown", 32'(bullet_fired), 1);
    fire_btn = 1'b0;
    step();
    repeat (8) tick_cycle();

    // Holding the button fires once
    pulses = 0;
    fire_btn = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bullet_fired) pulses++;
    end
    tick = 1'b0;
    chk("fire_hold_one", 32'(pulses), 1);
    fire_btn = 1'b0;
    step();

    // Edge while bullet on screen is lost for good
    bullet_onscreen = 1'b1;
    fire_btn = 1'b1;
    step();
    chk("fire_onscreen_drop", 32'(bullet_fired), 0);
    bullet_onscreen = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bullet_fired) pulses++;
    end
    chk("fire_no_deferred", 32'(pulses), 0);
    fire_btn = 1'b0;
    step();

    // Player hit three times
    for (int h = 0; h < 2; h++) begin
      player_hit = 1'b1;
      step();
      player_hit = 1'b0;
      chk("hit_state", 32'(game_state), 2);
      chk("hit_lives", 32'(lives), 2 - h);
      chk("hit_clear", 32'(clear_field), 1);
      step();
      chk("respawn_run", 32'(game_run), 0);
      player_hit = 1'b1;
      alien_hit = 1'b1;
      step();
      player_hit = 1'b0;
      alien_hit = 1'b0;
      chk("respawn_ignore_hit", 32'(lives), 2 - h);
      chk("respawn_ignore_score", 32'(score), 0);
      repeat (31) tick_cycle();
      chk("respawn_hold", 32'(game_state), 2);
      tick_cycle();
      chk("respawn_done", 32'(game_state), 1);
      step();
    end
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
    chk("last_hit_state", 32'(game_state), 4);
    chk("last_hit_lives", 32'(lives), 0);
    start = 1'b0;
    step();
    chk("lose_to_idle", 32'(game_state), 0);

    // Reached_Bottom beats Aliens_Defeated
    start = 1'b1;
    step();
    step();
    reached_bottom = 1'b1;
    aliens_defeated = 1'b1;
    step();
    reached_bottom = 1'b0;
    aliens_defeated = 1'b0;
    chk("prio_lose", 32'(game_state), 4);
    chk("prio_lives", 32'(lives), 0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    aliens_defeated = 1'b1;
    alien_hit = 1'b1;
    step();
    aliens_defeated = 1'b0;
    alien_hit = 1'b0;
    chk("win_state", 32'(game_state), 3);
    chk("win_score", 32'(score), 1);
    step();
    chk("win_hold", 32'(game_state), 3);
    chk("win_lives", 32'(lives), 3);

    // Score saturation
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk("restart_score", 32'(score), 0);
    exp_score = 0;
    alien_hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_score = (exp_score + 1 > 15) ? 15 : exp_score + 1;
    end
    alien_hit = 1'b0;
    chk("score_sat", 32'(score), exp_score);

    // Reset during respawn
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
    chk("pre_reset_state", 32'(game_state), 2);
    step();
    repeat (3) tick_cycle();
    reset = 1'b1;
    step();
    chk("rst_mid_state", 32'(game_state), 0);
    chk("rst_mid_clear", 32'(clear_field), 0);
    chk("rst_mid_run", 32'(game_run), 0);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("rst_after_clear", 32'(clear_field), 0);
    chk("rst_after_state", 32'(game_state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
